// File: rtl/filt_scan_pkg.sv
// Shared types and width helpers for the filt_scan debounce controller.
package filt_scan_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_STALL} state_e;

  function automatic int pw_f(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int cw_f(input int on_len, input int off_len);
    return $clog2(((on_len > off_len) ? on_len : off_len) + 1);
  endfunction

endpackage

// File: rtl/filt_chan_upd.sv
// Combinational filter update for one channel; shared across channels by the scanner.
module filt_chan_upd #(
  parameter int CW = 2
) (
  input  logic          s,
  input  logic          y,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] L,
  output logic          y_nx,
  output logic [CW-1:0] cnt_nx,
  output logic          toggle
);

  logic [CW:0] inc;

  assign inc = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    y_nx   = y;
    cnt_nx = '0;
    toggle = 1'b0;
    if (s != y) begin
      if (inc < {1'b0, L}) begin
        cnt_nx = inc[CW-1:0];
      end else begin
        toggle = 1'b1;
        y_nx   = s;
      end
    end
  end

endmodule

// File: rtl/filt_scan.sv
// Round-robin debounce controller with a valid/ready toggle event port.
// Define FILT_SCAN_SYNC_EN to add a 2-flop synchronizer on every input bit.
module filt_scan
  import filt_scan_pkg::*;
#(
  parameter  int CH      = 4,
  parameter  int ON_LEN  = 3,
  parameter  int OFF_LEN = 3,
  localparam int PW      = pw_f(CH),
  localparam int CW      = cw_f(ON_LEN, OFF_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CH-1:0] i,
  output logic [CH-1:0] y,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [PW-1:0] ev_ch,
  output logic          ev_level
);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CH-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  logic          evv_q, evv_d;
  logic [PW-1:0] evch_q, evch_d;
  logic          evlvl_q, evlvl_d;

  logic [CH-1:0] samp;
  logic          s_cur, y_nx, toggle;
  logic [CW-1:0] cnt_nx, len_sel;
  logic [PW-1:0] ptr_nx;

`ifdef FILT_SCAN_SYNC_EN
  logic [CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = i;
`endif

  assign s_cur   = samp[ptr_q];
  assign len_sel = y_q[ptr_q] ? CW'(OFF_LEN) : CW'(ON_LEN);
  assign ptr_nx  = (ptr_q == PW'(CH - 1)) ? '0 : ptr_q + PW'(1);

  filt_chan_upd #(.CW(CW)) u_upd (
    .s      (s_cur),
    .y      (y_q[ptr_q]),
    .cnt    (cnt_q[ptr_q]),
    .L      (len_sel),
    .y_nx   (y_nx),
    .cnt_nx (cnt_nx),
    .toggle (toggle)
  );

  // A stalled toggle leaves ptr and the channel untouched so it is re-sampled next cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    evv_d   = evv_q;
    evch_d  = evch_q;
    evlvl_d = evlvl_q;
    if (evv_q && ev_ready) evv_d = 1'b0;
    if (clr) begin
      state_d = S_IDLE;
      ptr_d   = '0;
      y_d     = '0;
      for (int c = 0; c < CH; c++) cnt_d[c] = '0;
      evv_d   = 1'b0;
      evch_d  = '0;
      evlvl_d = 1'b0;
    end else if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SCAN;
        default: begin
          if (toggle) begin
            if (!evv_q || ev_ready) begin
              y_d[ptr_q]   = y_nx;
              cnt_d[ptr_q] = '0;
              evv_d        = 1'b1;
              evch_d       = ptr_q;
              evlvl_d      = y_nx;
              ptr_d        = ptr_nx;
              state_d      = S_SCAN;
            end else begin
              state_d = S_STALL;
            end
          end else begin
            cnt_d[ptr_q] = cnt_nx;
            ptr_d        = ptr_nx;
            state_d      = S_SCAN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      y_q     <= '0;
      for (int c = 0; c < CH; c++) cnt_q[c] <= '0;
      evv_q   <= 1'b0;
      evch_q  <= '0;
      evlvl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      evv_q   <= evv_d;
      evch_q  <= evch_d;
      evlvl_q <= evlvl_d;
    end
  end

  assign y        = y_q;
  assign ev_valid = evv_q;
  assign ev_ch    = evch_q;
  assign ev_level = evlvl_q;

endmodule

// File: tb/tb_filt_scan.sv
// Randomized and directed bench for filt_scan against a behavioural debounce model.
module tb_filt_scan;
  import filt_scan_pkg::*;

  localparam int CH = 4;
  localparam int ON = 3;
  localparam int OFF = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] i = 4'h0;
  logic [3:0] y;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [1:0] ev_ch;
  logic       ev_level;

  int testsRun = 0;
  int failCount = 0;

  // Model: per-channel level and run length, scan position, running flag, event slot.
  int lvl [CH];
  int run [CH];
  int mptr, mact, mv, mch, mlev;

  filt_scan #(.CH(CH), .ON_LEN(ON), .OFF_LEN(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .i(i), .y(y),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_level(ev_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin lvl[c] = 0; run[c] = 0; end
    mptr = 0; mact = 0; mv = 0; mch = 0; mlev = 0;
  endtask

  // One clock edge worth of debounce behaviour, from the inputs currently driven.
  task automatic modelStep();
    int c, s, need, nv;
    if (!rst_n) begin modelReset(); return; end
    nv = (mv != 0 && ev_ready) ? 0 : mv;
    if (clr) begin
      modelReset();
      nv = 0;
    end else if (!en) begin
      mact = 0;
    end else if (mact == 0) begin
      mact = 1;
    end else begin
      c = mptr;
      s = int'(i[c]);
      need = (lvl[c] != 0) ? OFF : ON;
      if (s == lvl[c]) begin
        run[c] = 0;
        mptr = (mptr + 1) % CH;
      end else if (run[c] + 1 < need) begin
        run[c] += 1;
        mptr = (mptr + 1) % CH;
      end else if (mv == 0 || ev_ready) begin
        lvl[c] = s; run[c] = 0;
        nv = 1; mch = c; mlev = s;
        mptr = (mptr + 1) % CH;
      end
    end
    mv = nv;
  endtask

  function automatic logic [3:0] modelY();
    logic [3:0] v;
    for (int c = 0; c < CH; c++) v[c] = (lvl[c] != 0);
    return v;
  endfunction

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("y", 32'(y), 32'(modelY()));
    checkOutput("ev_valid", 32'(ev_valid), 32'(mv));
    checkOutput("ptr", 32'(dut.ptr_q), 32'(mptr));
    if (mv != 0) begin
      checkOutput("ev_ch", 32'(ev_ch), 32'(mch));
      checkOutput("ev_level", 32'(ev_level), 32'(mlev));
    end
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  initial begin
    int budget;
    modelReset();
    i = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_y", 32'(y), 32'h0);
    checkOutput("rst_valid", 32'(ev_valid), 32'h0);
    checkOutput("rst_ptr", 32'(dut.ptr_q), 32'h0);
    runCycles(5);
    rst_n = 1'b1;
    runCycles(4);

    en = 1'b1; ev_ready = 1'b1; i = 4'b0010;
    runCycles(16);
    checkOutput("rise_y", 32'(y), 32'h2);

    i = 4'b0110;
    runCycles(8);
    i = 4'b0010;
    runCycles(8);
    checkOutput("glitch_y", 32'(y), 32'h2);
    checkOutput("glitch_cnt2", 32'(dut.cnt_q[2]), 32'h0);

    i = 4'b0000;
    runCycles(16);
    checkOutput("fall1_y", 32'(y), 32'h0);

    ev_ready = 1'b0;
    budget = 8;
    while (mptr != 0 && budget > 0) begin applyStimulus(); budget--; end
    checkOutput("bp_align", 32'(mptr), 32'h0);
    i = 4'b1001;
    runCycles(14);
    checkOutput("bp_state", 32'(dut.state_q), 32'(S_STALL));
    checkOutput("bp_ptr", 32'(dut.ptr_q), 32'h3);
    checkOutput("bp_evch", 32'(ev_ch), 32'h0);
    checkOutput("bp_y", 32'(y), 32'h1);
    ev_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_nobubble_valid", 32'(ev_valid), 32'h1);
    checkOutput("bp_nobubble_ch", 32'(ev_ch), 32'h3);
    ev_ready = 1'b0;
    applyStimulus();

    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;
    checkOutput("clr_y", 32'(y), 32'h0);
    checkOutput("clr_valid", 32'(ev_valid), 32'h0);
    checkOutput("clr_state", 32'(dut.state_q), 32'(S_IDLE));

    ev_ready = 1'b1; i = 4'b0001;
    runCycles(16);
    checkOutput("fp_rise", 32'(y[0]), 32'h1);
    i = 4'b0000;
    budget = 20;
    while (run[0] != 2 && budget > 0) begin applyStimulus(); budget--; end
    checkOutput("fp_reach2", 32'(run[0]), 32'h2);
    en = 1'b0;
    runCycles(10);
    checkOutput("fp_hold_y", 32'(y[0]), 32'h1);
    checkOutput("fp_hold_cnt", 32'(dut.cnt_q[0]), 32'h2);
    en = 1'b1;
    runCycles(10);
    checkOutput("fp_fall_y", 32'(y[0]), 32'h0);

    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < CH; b++) if ($urandom_range(7) == 0) i[b] = ~i[b];
      en       = ($urandom_range(15) != 0);
      ev_ready = ($urandom_range(3) != 0);
      clr      = ($urandom_range(199) == 0);
      rst_n    = ($urandom_range(399) != 0);
      applyStimulus();
    end
    rst_n = 1'b1; clr = 1'b0;
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
